// File: rtl/intr_controller.sv
// -----------------------------------------------------------------------------
// intr_controller
//
// Interrupt controller that sits between on-chip interrupt sources and the
// CPU intr/inta handshake. A rising edge on any irq line latches a pending
// bit. Pending bits are filtered by a software mask and arbitrated with fixed
// priority (source 0 highest). The controller raises intr and, on acknowledge,
// returns the vector address of the winning source and retires its pending
// bit. Mask, pending and the last acknowledged id are visible on the IO bus.
//
// Register block (decoded on io_address[31:4], word index io_address[3:2]):
//   0 MASK      read/write, bits [N_SRC-1:0]
//   1 PENDING   read, write-1-to-clear
//   2 ACTIVE_ID read-only, id of last acknowledged source in bits [4:0]
//   3 unused    reads 0, writes ignored
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      asynchronous active-high reset, clears all state
//   irq        level request lines, a rising edge requests service
//   intr       interrupt request to the CPU
//   inta       interrupt acknowledge from the CPU
//   vec_out    vector address of the last acknowledged source
//   io_cs      IO bus select
//   io_rd      IO read strobe (combinational read data)
//   io_wr      IO write strobe (applied on the clock edge)
//   io_address IO address
//   io_d_in    IO write data
//   io_out     IO read data, 0 when not reading this block
// -----------------------------------------------------------------------------
module intr_controller #(
    parameter int unsigned N_SRC     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter logic [31:0] VEC_BASE  = 32'h0000_0200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq,
    output logic             intr,
    input  logic             inta,
    output logic [31:0]      vec_out,
    input  logic             io_cs,
    input  logic             io_rd,
    input  logic             io_wr,
    input  logic [31:0]      io_address,
    input  logic [31:0]      io_d_in,
    output logic [31:0]      io_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [4:0]       active_id_q, active_id_d;
    logic [31:0]      vec_q, vec_d;

    logic [N_SRC-1:0] set_vec;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] w1c_vec;
    logic [N_SRC-1:0] ack_clr;
    logic [4:0]       winner;
    logic             ack;
    logic             sel;
    logic             wr_mask;
    logic             wr_pend;
    logic [31:0]      rd_data;

    // Address bits below word granularity and write data above N_SRC are
    // intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{io_address[1:0], io_d_in};

    assign sel     = io_cs && (io_address[31:4] == BASE_ADDR[31:4]);
    assign wr_mask = sel && io_wr && (io_address[3:2] == 2'd0);
    assign wr_pend = sel && io_wr && (io_address[3:2] == 2'd1);

    assign set_vec  = irq & ~irq_q;
    assign eligible = pending_q & mask_q;
    assign w1c_vec  = wr_pend ? io_d_in[N_SRC-1:0] : '0;

    // Fixed priority: scanning downward leaves the lowest set index.
    always_comb begin
        winner = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 5'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < int'(N_SRC); gi++) begin : g_ack_clr
            assign ack_clr[gi] = ack && (winner == 5'(gi));
        end
    endgenerate

    // Edge sets are OR'd in after the clears, so a same-cycle set wins.
    assign pending_d = (pending_q & ~(w1c_vec | ack_clr)) | set_vec;
    assign mask_d    = wr_mask ? io_d_in[N_SRC-1:0] : mask_q;

    always_comb begin
        state_d     = state_q;
        intr        = 1'b0;
        ack         = 1'b0;
        active_id_d = active_id_q;
        vec_d       = vec_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                intr = 1'b1;
                // Request withdrawn by masking or W1C before the CPU answered.
                if (!(|eligible)) begin
                    state_d = IDLE;
                end else if (inta) begin
                    ack         = 1'b1;
                    active_id_d = winner;
                    vec_d       = VEC_BASE + {25'b0, winner, 2'b00};
                    state_d     = ACK;
                end
            end
            ACK: begin
                if (!inta) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            irq_q       <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            active_id_q <= '0;
            vec_q       <= '0;
        end else begin
            state_q     <= state_d;
            irq_q       <= irq;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            active_id_q <= active_id_d;
            vec_q       <= vec_d;
        end
    end

    assign vec_out = vec_q;

    always_comb begin
        rd_data = '0;
        case (io_address[3:2])
            2'd0:    rd_data[N_SRC-1:0] = mask_q;
            2'd1:    rd_data[N_SRC-1:0] = pending_q;
            2'd2:    rd_data[4:0]       = active_id_q;
            default: rd_data            = '0;
        endcase
    end

    assign io_out = (sel && io_rd) ? rd_data : '0;

endmodule

// File: tb/tb_intr_controller.sv
module tb_intr_controller;

    localparam logic [31:0] A_MASK = 32'h0000_0100;
    localparam logic [31:0] A_PEND = 32'h0000_0104;
    localparam logic [31:0] A_ID   = 32'h0000_0108;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq;
    logic        intr;
    logic        inta;
    logic [31:0] vec_out;
    logic        io_cs;
    logic        io_rd;
    logic        io_wr;
    logic [31:0] io_address;
    logic [31:0] io_d_in;
    logic [31:0] io_out;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state for the randomized phase
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    logic [7:0] m_irq;

    intr_controller #(
        .N_SRC    (8),
        .BASE_ADDR(32'h0000_0100),
        .VEC_BASE (32'h0000_0200)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq       (irq),
        .intr      (intr),
        .inta      (inta),
        .vec_out   (vec_out),
        .io_cs     (io_cs),
        .io_rd     (io_rd),
        .io_wr     (io_wr),
        .io_address(io_address),
        .io_d_in   (io_d_in),
        .io_out    (io_out)
    );

    always #50 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        io_cs      = 1'b1;
        io_rd      = 1'b1;
        io_address = a;
        #1;
        d          = io_out;
        io_cs      = 1'b0;
        io_rd      = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        io_cs      = 1'b1;
        io_wr      = 1'b1;
        io_address = a;
        io_d_in    = d;
        tick();
        io_cs      = 1'b0;
        io_wr      = 1'b0;
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    initial begin
        logic [31:0] d;
        logic [7:0]  new_irq;
        logic [7:0]  edges;
        logic [31:0] bus_d;
        int          op;
        int          w;

        reset = 1'b1; irq = '0; inta = 1'b0;
        io_cs = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
        io_address = '0; io_d_in = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        chk("rst_intr", {31'b0, intr}, 32'h0);
        chk("rst_vec", vec_out, 32'h0);
        chk("rst_io_out", io_out, 32'h0);
        chk_reg("rst_mask", A_MASK, 32'h0);
        chk_reg("rst_pend", A_PEND, 32'h0);
        chk_reg("rst_id", A_ID, 32'h0);

        // Single source, full handshake
        wr(A_MASK, 32'h01);
        irq = 8'h01;
        tick();
        chk_reg("t1_pend_set", A_PEND, 32'h01);
        chk("t1_intr_not_yet", {31'b0, intr}, 32'h0);
        tick();
        chk("t1_intr_up", {31'b0, intr}, 32'h1);
        inta = 1'b1;
        tick();
        chk("t1_vec", vec_out, 32'h200);
        chk_reg("t1_pend_clr", A_PEND, 32'h0);
        chk("t1_intr_ack", {31'b0, intr}, 32'h0);
        chk_reg("t1_id", A_ID, 32'h0);
        inta = 1'b0;
        tick();
        chk("t1_intr_idle", {31'b0, intr}, 32'h0);
        irq = 8'h00;
        tick();

        // Two simultaneous edges, priority order
        wr(A_MASK, 32'hFF);
        irq = 8'h24;
        tick();
        chk_reg("t2_pend", A_PEND, 32'h24);
        tick();
        chk("t2_intr", {31'b0, intr}, 32'h1);
        inta = 1'b1;
        tick();
        chk("t2_vec_a", vec_out, 32'h208);
        chk_reg("t2_pend_a", A_PEND, 32'h20);
        chk_reg("t2_id_a", A_ID, 32'h2);
        inta = 1'b0;
        tick();
        chk("t2_intr_gap", {31'b0, intr}, 32'h0);
        tick();
        chk("t2_intr_again", {31'b0, intr}, 32'h1);
        inta = 1'b1;
        tick();
        chk("t2_vec_b", vec_out, 32'h214);
        chk_reg("t2_id_b", A_ID, 32'h5);
        chk_reg("t2_pend_b", A_PEND, 32'h0);
        inta = 1'b0;
        tick();
        irq = 8'h00;
        tick();

        // Masked pending, unmask, then withdraw by W1C
        wr(A_MASK, 32'h00);
        irq = 8'h08;
        tick();
        chk_reg("t3_pend_masked", A_PEND, 32'h08);
        tick();
        tick();
        chk("t3_intr_masked", {31'b0, intr}, 32'h0);
        wr(A_MASK, 32'h08);
        tick();
        chk("t3_intr_unmasked", {31'b0, intr}, 32'h1);
        wr(A_PEND, 32'h08);
        chk_reg("t3_pend_w1c", A_PEND, 32'h0);
        tick();
        chk("t3_intr_withdrawn", {31'b0, intr}, 32'h0);
        irq = 8'h00;
        tick();

        // New edge in the very cycle the bit is retired: set wins
        wr(A_MASK, 32'h02);
        irq = 8'h02;
        tick();
        tick();
        chk("t4_intr", {31'b0, intr}, 32'h1);
        irq = 8'h00;
        tick();
        irq  = 8'h02;
        inta = 1'b1;
        tick();
        chk("t4_vec", vec_out, 32'h204);
        chk_reg("t4_pend_kept", A_PEND, 32'h02);
        chk("t4_intr_ack", {31'b0, intr}, 32'h0);
        inta = 1'b0;
        tick();
        tick();
        chk("t4_intr_rereq", {31'b0, intr}, 32'h1);
        inta = 1'b1;
        tick();
        inta = 1'b0;
        tick();
        chk_reg("t4_pend_done", A_PEND, 32'h0);
        irq = 8'h00;
        tick();

        // Asynchronous reset in the middle of a request
        wr(A_MASK, 32'h0F);
        irq = 8'h0F;
        tick();
        tick();
        chk("t5_intr_pre", {31'b0, intr}, 32'h1);
        reset = 1'b1;
        #1;
        chk("t5_intr_async", {31'b0, intr}, 32'h0);
        chk("t5_vec_async", vec_out, 32'h0);
        chk_reg("t5_pend_async", A_PEND, 32'h0);
        chk_reg("t5_mask_async", A_MASK, 32'h0);
        irq = 8'h00;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("t5_intr_after", {31'b0, intr}, 32'h0);
        wr(A_MASK, 32'h0F);
        tick();
        tick();
        chk("t5_intr_no_edge", {31'b0, intr}, 32'h0);
        chk_reg("t5_pend_none", A_PEND, 32'h0);

        // Mask width, unmapped accesses, read-only id
        wr(A_MASK, 32'hFFFF_FF55);
        chk_reg("t6_mask_width", A_MASK, 32'h55);
        irq = 8'h80;
        tick();
        chk_reg("t6_pend", A_PEND, 32'h80);
        wr(32'h0000_0110, 32'hFFFF_FFFF);
        wr(32'h0000_010C, 32'hFFFF_FFFF);
        wr(32'h0000_0114, 32'hFFFF_FFFF);
        wr(A_ID, 32'h0000_0007);
        chk_reg("t6_mask_kept", A_MASK, 32'h55);
        chk_reg("t6_pend_kept", A_PEND, 32'h80);
        chk_reg("t6_id_ro", A_ID, 32'h0);
        chk_reg("t6_rd_110", 32'h0000_0110, 32'h0);
        chk_reg("t6_rd_10c", 32'h0000_010C, 32'h0);
        io_cs = 1'b0; io_rd = 1'b1; io_address = A_PEND;
        #1;
        chk("t6_rd_no_cs", io_out, 32'h0);
        io_rd = 1'b0;
        wr(A_PEND, 32'h80);
        chk_reg("t6_pend_clr", A_PEND, 32'h0);
        chk("t6_intr", {31'b0, intr}, 32'h0);

        // Randomized phase against the reference model
        m_pend = 8'h00;
        m_mask = 8'h55;
        m_irq  = 8'h80;
        for (int r = 0; r < 4; r++) begin
            for (int it = 0; it < 16; it++) begin
                new_irq = 8'($urandom);
                op      = int'($urandom_range(0, 3));
                bus_d   = $urandom;
                irq     = new_irq;
                if (op == 0) begin
                    io_cs = 1'b1; io_wr = 1'b1; io_address = A_PEND; io_d_in = bus_d;
                end else if (op == 1) begin
                    io_cs = 1'b1; io_wr = 1'b1; io_address = A_MASK; io_d_in = bus_d;
                end
                tick();
                io_cs = 1'b0; io_wr = 1'b0;
                edges = new_irq & ~m_irq;
                m_irq = new_irq;
                if (op == 0) m_pend = m_pend & ~bus_d[7:0];
                if (op == 1) m_mask = bus_d[7:0];
                m_pend = m_pend | edges;
                chk_reg("rnd_pend", A_PEND, {24'b0, m_pend});
                chk_reg("rnd_mask", A_MASK, {24'b0, m_mask});
            end
            tick();
            tick();
            chk("rnd_intr_settle", {31'b0, intr}, {31'b0, ((m_pend & m_mask) != 8'h00)});
            while ((m_pend & m_mask) != 8'h00) begin
                w = lowest(m_pend & m_mask);
                for (int k = 0; k < 4; k++) begin
                    if (intr) break;
                    tick();
                end
                chk("rnd_wait_intr", {31'b0, intr}, 32'h1);
                inta = 1'b1;
                tick();
                chk("rnd_vec", vec_out, 32'h200 + 32'(4 * w));
                chk_reg("rnd_id", A_ID, 32'(w));
                m_pend = m_pend & ~(8'h01 << w);
                chk_reg("rnd_pend_ack", A_PEND, {24'b0, m_pend});
                inta = 1'b0;
                tick();
            end
            tick();
            chk("rnd_intr_drained", {31'b0, intr}, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/intr_controller.md
Name: intr_controller

Overview:
- Interrupt controller between on-chip interrupt sources and the MIPS_CPU intr/inta handshake.
- Latches rising-edge requests from N_SRC sources into a pending register, applies a software mask and fixed priority, and drives intr to the CPU.
- On acknowledge, supplies the vector address of the winning source and retires it.
- Mask and pending state are reachable over the CPU IO bus (io_cs/io_rd/io_wr, dm_address, dm_d_in, io_out).

Parameters:
- N_SRC, 8, number of interrupt sources (1..32).
- BASE_ADDR, 32'h0000_0100, IO address of register block; decode on address[31:4].
- VEC_BASE, 32'h0000_0200, vector of source 0; source k vector = VEC_BASE + 4*k.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- irq  in  N_SRC  source request lines, synchronous to clk, level; rising edge = request.
- intr  out  1  interrupt request to CPU.
- inta  in  1  interrupt acknowledge from CPU.
- vec_out  out  32  vector address of acknowledged source.
- io_cs  in  1  IO bus select.
- io_rd  in  1  IO read strobe.
- io_wr  in  1  IO write strobe.
- io_address  in  32  IO address (dm_address).
- io_d_in  in  32  IO write data (dm_d_in).
- io_out  out  32  IO read data.

Behaviour:
- Reset values: intr=0, vec_out=0, io_out=0, mask=0 (all disabled), pending=0, irq_q=0, active_id=0, state=IDLE.
- Edge detect: irq_q <= irq each cycle; set_vec = irq & ~irq_q; pending |= set_vec. Masked sources still latch pending.
- Registers (sel = io_cs & io_address[31:4]==BASE_ADDR[31:4], index io_address[3:2]):
  - 0 MASK: read/write, bits [N_SRC-1:0]; upper bits read 0, writes ignored.
  - 1 PENDING: read; write-1-to-clear.
  - 2 ACTIVE_ID: read-only, {27'b0, active_id[4:0]}.
  - 3: reads 0, writes ignored.
- Writes take effect on the posedge where sel & io_wr. Reads are combinational: io_out = register when sel & io_rd, else 0.
- Pending bit updates:
  - Set and clear of the same bit in one cycle (edge vs W1C or ack-retire): set wins, bit stays 1.
  - Clears of different bits in the same cycle both apply.
- Eligible = pending & mask. Winner = lowest-index eligible bit, with fixed priority (source 0 highest).
- FSM:
  - IDLE: intr=0. If eligible != 0, go to REQ next cycle (intr rises 1 cycle after the pending set is visible).
  - REQ: intr=1.
    - If eligible becomes 0 (masked or W1C'd) before inta, return to IDLE and deassert intr.
    - On posedge with inta=1: capture winner into active_id, vec_out <= VEC_BASE + {winner,2'b00}, clear pending[winner], go to ACK.
    - The winner is evaluated on the acknowledge cycle, so a higher-priority request arriving during REQ wins.
  - ACK: intr=0; vec_out held. When inta=0, go to IDLE. Re-request can occur no sooner than 1 cycle after inta drops.
- inta while IDLE or ACK: ignored (no pending change, vec_out unchanged).
- vec_out and active_id hold their last values until the next acknowledge.
- Reset mid-handshake: intr drops immediately (asynchronous), state=IDLE, pending lost.
- Width: vec_out addition is 32-bit wrap-around, unsigned.

Test Plan:
- Reset, mask=0x01, pulse irq[0] 0->1 -> pending=0x01 one cycle later, intr=1 one cycle after that. Assert inta -> vec_out=0x200, pending=0x00, intr=0, ACTIVE_ID reads 0. Drop inta -> state IDLE.
- mask=0xFF, rising edges on irq[5] and irq[2] in the same cycle, then ack -> vec_out=0x208, pending=0x20, intr re-asserts after inta drops; second ack -> vec_out=0x214.
- mask=0x00, pulse irq[3] -> PENDING reads 0x08, intr stays 0. Write MASK=0x08 -> intr=1. Write PENDING=0x08 before inta -> pending=0, intr=0.
- In the cycle pending[1] is retired by ack, a new rising edge on irq[1] -> pending[1] remains 1, intr re-asserts after ACK completes.
- Assert reset during REQ with pending=0x0F -> intr=0, pending=0, mask=0, vec_out=0 immediately; no intr after reset release until a new edge and mask write.
- Unmapped access (address 0x110, or index 3 at 0x10C) -> io_out=0, MASK/PENDING unchanged.
